// File: rtl/stage2_id_pkg.sv
// Shared decode constants for the ID stage: opcodes, funct codes, ALU op encodings
// and the per-instruction control bundle.
package stage2_id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLL = 6'h00;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_SLL = 3'd5
    } aluop_e;

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       alusrc;
        aluop_e     aluop;
        logic [4:0] dest;
    } ctrl_t;

    // Branch target: PC+4 plus the word-scaled, sign-extended 16-bit offset.
    function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                  input logic [15:0] imm16);
        return pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32-entry register file, two combinational read ports, one write port.
// $0 is hard-wired to zero; a write in the same cycle bypasses to the read ports.
module regfile_2r1w #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  we,
    input  logic [4:0]            waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [4:0]            raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic [4:0]            raddr2,
    output logic [DATA_WIDTH-1:0] rdata2
);

    logic [DATA_WIDTH-1:0] mem [32];
    logic                  wr_en;

    assign wr_en = we && (waddr != 5'd0);

    // NOTE: the array sits on the async reset, so it maps to flops rather than
    // a RAM macro; that is intended, since every register must clear on rstb.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [4:0] ra);
        if (ra == 5'd0)                 return '0;
        else if (wr_en && ra == waddr)  return wdata;
        else                            return mem[ra];
    endfunction

    assign rdata1 = read_port(raddr1);
    assign rdata2 = read_port(raddr2);

endmodule

// File: rtl/stage2_id.sv
// Instruction decode stage: decode, register read, branch resolution, hazard stalls, ID/EX register.
// Optional ID_BRANCH_FWD_EN forwards an EX/MEM ALU result into the branch comparator.
module stage2_id
    import stage2_id_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [31:0]           instr,
    input  logic [31:0]           pc_plus4,
    input  logic                  wb_we,
    input  logic [4:0]            wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  exmem_regwrite,
    input  logic                  exmem_memread,
    input  logic [4:0]            exmem_rd,
    input  logic [DATA_WIDTH-1:0] exmem_alu_result,
    output logic                  pc_src,
    output logic [31:0]           pc_plus4_plusimm16,
    output logic                  hold_pc,
    output logic                  hold_if,
    output logic                  if_flush,
    output logic [DATA_WIDTH-1:0] idex_rs_data,
    output logic [DATA_WIDTH-1:0] idex_rt_data,
    output logic [DATA_WIDTH-1:0] idex_imm,
    output logic [4:0]            idex_rs,
    output logic [4:0]            idex_rt,
    output logic [4:0]            idex_rd,
    output logic [4:0]            idex_shamt,
    output logic                  idex_regwrite,
    output logic                  idex_memread,
    output logic                  idex_memwrite,
    output logic                  idex_alusrc,
    output logic [2:0]            idex_aluop
);

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];

    logic [DATA_WIDTH-1:0] rs_val, rt_val, imm_sext;

    assign imm_sext = {{(DATA_WIDTH-16){imm16[15]}}, imm16};

    regfile_2r1w #(.DATA_WIDTH(DATA_WIDTH)) u_regfile (
        .clk    (clk),
        .rstb   (rstb),
        .we     (wb_we),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs),
        .rdata1 (rs_val),
        .raddr2 (rt),
        .rdata2 (rt_val)
    );

    ctrl_t dec;
    logic  valid, uses_rt, is_beq, is_bne;

    // NOTE: every output of this block is given a default first, so no path
    // through the case statements can leave a value held (no latch).
    always_comb begin
        dec     = '0;
        valid   = 1'b0;
        uses_rt = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                valid        = 1'b1;
                uses_rt      = 1'b1;
                dec.regwrite = 1'b1;
                dec.dest     = rd;
                case (funct)
                    FN_ADD:  dec.aluop = ALU_ADD;
                    FN_SUB:  dec.aluop = ALU_SUB;
                    FN_AND:  dec.aluop = ALU_AND;
                    FN_OR:   dec.aluop = ALU_OR;
                    FN_SLT:  dec.aluop = ALU_SLT;
                    FN_SLL:  dec.aluop = ALU_SLL;
                    default: valid     = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW: begin
                valid        = 1'b1;
                dec.regwrite = 1'b1;
                dec.memread  = (opcode == OP_LW);
                dec.alusrc   = 1'b1;
                dec.dest     = rt;
            end
            OP_SW: begin
                valid        = 1'b1;
                uses_rt      = 1'b1;
                dec.memwrite = 1'b1;
                dec.alusrc   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                valid   = 1'b1;
                uses_rt = 1'b1;
                is_beq  = (opcode == OP_BEQ);
                is_bne  = (opcode == OP_BNE);
            end
            default: ;
        endcase
        if (dec.dest == 5'd0) dec.regwrite = 1'b0;
        if (!valid)           dec          = '0;
    end

    // Hazard detection: a stall lasts only as long as its cause, since it is
    // recomputed every cycle from the ID/EX and EX/MEM state.
    logic load_use, rs_busy, rt_busy, branch_stall, stall, exmem_blocks;
    logic [DATA_WIDTH-1:0] br_a, br_b;

    assign load_use = idex_memread && (idex_rd != 5'd0) &&
                      ((idex_rd == rs) || (uses_rt && idex_rd == rt));

`ifdef ID_BRANCH_FWD_EN
    assign exmem_blocks = exmem_memread;
    assign br_a = (exmem_regwrite && !exmem_memread && exmem_rd != 5'd0 && exmem_rd == rs)
                  ? exmem_alu_result : rs_val;
    assign br_b = (exmem_regwrite && !exmem_memread && exmem_rd != 5'd0 && exmem_rd == rt)
                  ? exmem_alu_result : rt_val;
`else
    logic unused_exmem_alu_result;
    assign unused_exmem_alu_result = ^exmem_alu_result;
    assign exmem_blocks = exmem_memread || exmem_regwrite;
    assign br_a = rs_val;
    assign br_b = rt_val;
`endif

    assign rs_busy = (rs != 5'd0) &&
                     ((idex_regwrite && idex_rd == rs) || (exmem_blocks && exmem_rd == rs));
    assign rt_busy = (rt != 5'd0) &&
                     ((idex_regwrite && idex_rd == rt) || (exmem_blocks && exmem_rd == rt));

    assign branch_stall = (is_beq || is_bne) && (rs_busy || rt_busy);
    assign stall        = load_use || branch_stall;

    assign hold_pc  = stall;
    assign hold_if  = stall;
    assign pc_src   = !stall && ((is_beq && br_a == br_b) || (is_bne && br_a != br_b));
    assign if_flush = pc_src;
    assign pc_plus4_plusimm16 = branch_target(pc_plus4, imm16);

    logic bubble;
    assign bubble = stall || !valid;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb || bubble) begin
            idex_rs_data  <= '0;
            idex_rt_data  <= '0;
            idex_imm      <= '0;
            idex_rs       <= '0;
            idex_rt       <= '0;
            idex_rd       <= '0;
            idex_shamt    <= '0;
            idex_regwrite <= 1'b0;
            idex_memread  <= 1'b0;
            idex_memwrite <= 1'b0;
            idex_alusrc   <= 1'b0;
            idex_aluop    <= '0;
        end else begin
            idex_rs_data  <= rs_val;
            idex_rt_data  <= rt_val;
            idex_imm      <= imm_sext;
            idex_rs       <= rs;
            idex_rt       <= rt;
            idex_rd       <= dec.dest;
            idex_shamt    <= shamt;
            idex_regwrite <= dec.regwrite;
            idex_memread  <= dec.memread;
            idex_memwrite <= dec.memwrite;
            idex_alusrc   <= dec.alusrc;
            idex_aluop    <= dec.aluop;
        end
    end

endmodule

// File: tb/tb_stage2_id.sv
// Directed bench for stage2_id: expected ID/EX contents are queued as each instruction
// is presented and compared one cycle later; fetch-control outputs are checked in-cycle.
module tb_stage2_id;
    import stage2_id_pkg::*;

    logic        clk = 1'b0;
    logic        rstb;
    logic [31:0] instr, pc_plus4, wb_data, exmem_alu_result;
    logic        wb_we, exmem_regwrite, exmem_memread;
    logic [4:0]  wb_rd, exmem_rd;
    logic        pc_src, hold_pc, hold_if, if_flush;
    logic [31:0] pc_plus4_plusimm16, idex_rs_data, idex_rt_data, idex_imm;
    logic [4:0]  idex_rs, idex_rt, idex_rd, idex_shamt;
    logic        idex_regwrite, idex_memread, idex_memwrite, idex_alusrc;
    logic [2:0]  idex_aluop;

    always #5 clk = ~clk;

    stage2_id #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rstb(rstb), .instr(instr), .pc_plus4(pc_plus4),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .exmem_regwrite(exmem_regwrite), .exmem_memread(exmem_memread),
        .exmem_rd(exmem_rd), .exmem_alu_result(exmem_alu_result),
        .pc_src(pc_src), .pc_plus4_plusimm16(pc_plus4_plusimm16),
        .hold_pc(hold_pc), .hold_if(hold_if), .if_flush(if_flush),
        .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data), .idex_imm(idex_imm),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd), .idex_shamt(idex_shamt),
        .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
        .idex_memwrite(idex_memwrite), .idex_alusrc(idex_alusrc), .idex_aluop(idex_aluop)
    );

    typedef struct packed {
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd, shamt;
        logic        regwrite, memread, memwrite, alusrc;
        logic [2:0]  aluop;
    } idex_t;

    idex_t sb[$];
    int    checks = 0;
    int    failures = 0;

    localparam idex_t BUB = '0;

    function automatic idex_t mk(input logic [31:0] rsd, rtd, imm,
                                 input logic [4:0] rs, rt, rd, sh,
                                 input logic rw, mr, mw, as, input logic [2:0] op);
        idex_t e;
        e = '{rs_data: rsd, rt_data: rtd, imm: imm, rs: rs, rt: rt, rd: rd, shamt: sh,
              regwrite: rw, memread: mr, memwrite: mw, alusrc: as, aluop: op};
        return e;
    endfunction

    function automatic idex_t observed();
        return mk(idex_rs_data, idex_rt_data, idex_imm, idex_rs, idex_rt, idex_rd, idex_shamt,
                  idex_regwrite, idex_memread, idex_memwrite, idex_alusrc, idex_aluop);
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // In-cycle fetch control: {pc_src, if_flush, hold_pc, hold_if}
    task automatic check_ctl(input string tag, input logic taken, input logic stall);
        check(tag, {124'd0, pc_src, if_flush, hold_pc, hold_if}, {124'd0, taken, taken, stall, stall});
    endtask

    task automatic issue(input logic [31:0] ins, input idex_t e);
        instr = ins;
        sb.push_back(e);
        #1;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
        end else begin
            check(tag, observed(), sb.pop_front());
        end
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        exmem_regwrite = 1'b0; exmem_memread = 1'b0; exmem_rd = '0; exmem_alu_result = '0;
    endtask

    localparam logic [31:0] ADD3  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    localparam logic [31:0] ADD4  = {6'h00, 5'd2, 5'd2, 5'd4, 5'd0, 6'h20};
    localparam logic [31:0] LW2   = {6'h23, 5'd1, 5'd2, 16'h0000};
    localparam logic [31:0] BEQ50 = {6'h04, 5'd5, 5'd0, 16'h0002};
    localparam logic [31:0] BNE21 = {6'h05, 5'd2, 5'd1, 16'h0001};

    idex_t       nop_e;
    logic [5:0]  fns [4];
    logic [2:0]  ops [4];

    initial begin
        nop_e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALU_SLL);
        fns = '{FN_SUB, FN_AND, FN_OR, FN_SLT};
        ops = '{ALU_SUB, ALU_AND, ALU_OR, ALU_SLT};

        rstb = 1'b0; instr = '0; pc_plus4 = '0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        exmem_regwrite = 1'b0; exmem_memread = 1'b0; exmem_rd = '0; exmem_alu_result = '0;

        // Reset: ID/EX stays cleared even with a valid instruction present
        repeat (2) @(posedge clk);
        #1;
        check("reset_idex", observed(), BUB);
        check_ctl("reset_ctl", 1'b0, 1'b0);
        instr = ADD3;
        @(posedge clk);
        #1;
        check("reset_hold_idex", observed(), BUB);
        rstb = 1'b1;

        // Preload $1=5, $2=7 through the writeback port
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
        issue(32'h0, nop_e); tick("preload1");
        wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'd7;
        issue(32'h0, nop_e); tick("preload2");

        // R-type decode
        issue(ADD3, mk(5, 7, 32'h1820, 1, 2, 3, 0, 1, 0, 0, 0, ALU_ADD));
        check_ctl("add_ctl", 1'b0, 1'b0);
        tick("add_idex");
        for (int i = 0; i < 4; i++) begin
            issue(enc_r(1, 2, 4, 0, fns[i]),
                  mk(5, 7, {16'h0, 5'd4, 5'd0, fns[i]}, 1, 2, 4, 0, 1, 0, 0, 0, ops[i]));
            tick($sformatf("rtype_fn%0h", fns[i]));
        end
        issue(enc_r(0, 2, 6, 4, FN_SLL), mk(0, 7, 32'h3100, 0, 2, 6, 4, 1, 0, 0, 0, ALU_SLL));
        tick("sll_idex");
        issue(enc_r(1, 2, 0, 0, FN_ADD), mk(5, 7, 32'h0020, 1, 2, 0, 0, 0, 0, 0, 0, ALU_ADD));
        tick("add_rd0_noregwrite");
        issue(enc_r(1, 2, 3, 0, 6'h21), BUB);
        tick("bad_funct_bubble");
        issue(enc_i(6'h3F, 1, 2, 16'h1234), BUB);
        tick("bad_opcode_bubble");

        // addi $5,$0,1 then beq $5,$0: branch waits for $5
        issue(enc_i(OP_ADDI, 0, 5, 16'h0001), mk(0, 0, 1, 0, 5, 5, 0, 1, 0, 0, 1, ALU_ADD));
        tick("addi_idex");
        pc_plus4 = 32'h0040_0010;
        issue(BEQ50, BUB);
        check_ctl("addi_beq_stall1", 1'b0, 1'b1);
        check("addi_beq_target", {96'd0, pc_plus4_plusimm16}, {96'd0, 32'h0040_0018});
        tick("addi_beq_bubble1");
        exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_alu_result = 32'd1;
`ifdef ID_BRANCH_FWD_EN
        issue(BEQ50, mk(0, 0, 2, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        check_ctl("addi_beq_fwd_not_taken", 1'b0, 1'b0);
        tick("addi_beq_fwd_idex");
`else
        issue(BEQ50, BUB);
        check_ctl("addi_beq_stall2", 1'b0, 1'b1);
        tick("addi_beq_bubble2");
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'd1;
        issue(BEQ50, mk(1, 0, 2, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        check_ctl("addi_beq_not_taken", 1'b0, 1'b0);
        tick("addi_beq_idex");
`endif

        // Taken / not-taken branches and target arithmetic
        pc_plus4 = 32'h0040_0024;
        issue(enc_i(OP_BEQ, 1, 1, 16'h0003), mk(5, 5, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        check_ctl("beq_taken", 1'b1, 1'b0);
        check("beq_target", {96'd0, pc_plus4_plusimm16}, {96'd0, 32'h0040_0030});
        tick("beq_idex");
        issue(enc_i(OP_BNE, 1, 2, 16'hFFFF), mk(5, 7, 32'hFFFF_FFFF, 1, 2, 0, 31, 0, 0, 0, 0, 0));
        check_ctl("bne_taken", 1'b1, 1'b0);
        check("bne_neg_target", {96'd0, pc_plus4_plusimm16}, {96'd0, 32'h0040_0020});
        tick("bne_idex");
        issue(enc_i(OP_BNE, 1, 1, 16'h0004), mk(5, 5, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        check_ctl("bne_not_taken", 1'b0, 1'b0);
        tick("bne_nt_idex");

        // Load-use: lw $2 then add $4,$2,$2
        issue(LW2, mk(5, 7, 0, 1, 2, 2, 0, 1, 1, 0, 1, ALU_ADD));
        check_ctl("lw_ctl", 1'b0, 1'b0);
        tick("lw_idex");
        issue(ADD4, BUB);
        check_ctl("lu_stall", 1'b0, 1'b1);
        tick("lu_bubble");
        issue(ADD4, mk(7, 7, 32'h2020, 2, 2, 4, 0, 1, 0, 0, 0, ALU_ADD));
        check_ctl("lu_release", 1'b0, 1'b0);
        tick("lu_add_idex");

        // lw then addi writing the same rt: no dependence
        issue(LW2, mk(5, 7, 0, 1, 2, 2, 0, 1, 1, 0, 1, ALU_ADD)); tick("lw2_idex");
        issue(enc_i(OP_ADDI, 1, 2, 16'h0004), mk(5, 7, 4, 1, 2, 2, 0, 1, 0, 0, 1, ALU_ADD));
        check_ctl("lu_addi_nostall", 1'b0, 1'b0);
        tick("addi2_idex");

        // lw then sw reading rt: stalls once
        issue(LW2, mk(5, 7, 0, 1, 2, 2, 0, 1, 1, 0, 1, ALU_ADD)); tick("lw3_idex");
        issue(enc_i(OP_SW, 1, 2, 16'h0000), BUB);
        check_ctl("lu_sw_stall", 1'b0, 1'b1);
        tick("sw_bubble");
        issue(enc_i(OP_SW, 1, 2, 16'h0000), mk(5, 7, 0, 1, 2, 0, 0, 0, 0, 1, 1, ALU_ADD));
        tick("sw_idex");

        // lw $2 then bne $2,$1: two stall cycles, then taken
        issue(LW2, mk(5, 7, 0, 1, 2, 2, 0, 1, 1, 0, 1, ALU_ADD)); tick("lw4_idex");
        issue(BNE21, BUB);
        check_ctl("lb_stall1", 1'b0, 1'b1);
        tick("lb_bubble1");
        exmem_regwrite = 1'b1; exmem_memread = 1'b1; exmem_rd = 5'd2; exmem_alu_result = 32'h100;
        issue(BNE21, BUB);
        check_ctl("lb_stall2", 1'b0, 1'b1);
        tick("lb_bubble2");
        wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'd7;
        issue(BNE21, mk(7, 5, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0));
        check_ctl("lb_taken", 1'b1, 1'b0);
        tick("lb_bne_idex");

        // $0 is never written; same-cycle writeback bypasses to the read
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        issue(32'h0, nop_e); tick("wb_r0_nop");
        issue(enc_r(0, 0, 8, 0, FN_ADD), mk(0, 0, 32'h4020, 0, 0, 8, 0, 1, 0, 0, 0, ALU_ADD));
        tick("r0_reads_zero");
        wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234_5678;
        issue(enc_r(7, 1, 9, 0, FN_ADD),
              mk(32'h1234_5678, 5, 32'h4820, 7, 1, 9, 0, 1, 0, 0, 0, ALU_ADD));
        tick("wb_bypass_rs");
        issue(enc_r(1, 7, 9, 0, FN_ADD),
              mk(5, 32'h1234_5678, 32'h4820, 1, 7, 9, 0, 1, 0, 0, 0, ALU_ADD));
        tick("wb_stored_rt");

        // Reset in the middle of a load-use stall
        issue(LW2, mk(5, 7, 0, 1, 2, 2, 0, 1, 1, 0, 1, ALU_ADD)); tick("lw5_idex");
        instr = ADD4;
        #1;
        check_ctl("mid_stall", 1'b0, 1'b1);
        rstb = 1'b0;
        #1;
        check("rst_idex_clear", observed(), BUB);
        check_ctl("rst_no_stall", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rstb = 1'b1;
        issue(ADD4, mk(0, 0, 32'h2020, 2, 2, 4, 0, 1, 0, 0, 0, ALU_ADD));
        check_ctl("post_rst_no_stall", 1'b0, 1'b0);
        tick("post_rst_add_regs_cleared");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
